// File: rtl/coco_video_pkg.sv
// Shared types, limits and the colour-replication helper for the CoCo video output stage.
package coco_video_pkg;

  localparam int unsigned MEAS_W   = 12;
  localparam int unsigned MEAS_MAX = 4095;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_VS
  } meas_state_t;

  // MSB-first cyclic replication of an in_w-bit value, truncated to out_w bits.
  // When in_w >= out_w this reduces to value[in_w-1 -: out_w].
  function automatic logic [31:0] expand(input logic [31:0] value,
                                         input int unsigned in_w,
                                         input int unsigned out_w);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < out_w) res[5'(out_w - 1 - i)] = value[5'(in_w - 1 - (i % in_w))];
    end
    return res;
  endfunction

endpackage

// File: rtl/coco_video_meas.sv
// Active-area measurement: counts active pixels per line and active lines per frame,
// latching the last complete frame on each vsync rising edge. Advances only on ce_pixel.
module coco_video_meas
  import coco_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pixel,
  input  logic              de,
  input  logic              vsync,
  output logic [MEAS_W-1:0] h_active,
  output logic [MEAS_W-1:0] v_active,
  output logic              meas_valid
);

  localparam logic [MEAS_W-1:0] CNT_MAX = MEAS_W'(MEAS_MAX);

  meas_state_t       state_q, state_d;
  logic [MEAS_W-1:0] pix_q, pix_d;
  logic [MEAS_W-1:0] line_q, line_d;
  logic [MEAS_W-1:0] lw_q, lw_d;
  logic [MEAS_W-1:0] h_d, v_d;
  logic              valid_d;
  logic              vs_prev, de_prev;
  logic              vs_rise, de_fall;

  assign vs_rise = vsync & ~vs_prev;
  assign de_fall = de_prev & ~de;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      line_q     <= '0;
      lw_q       <= '0;
      h_active   <= '0;
      v_active   <= '0;
      meas_valid <= 1'b0;
      vs_prev    <= 1'b0;
      de_prev    <= 1'b0;
    end else if (ce_pixel) begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      lw_q       <= lw_d;
      h_active   <= h_d;
      v_active   <= v_d;
      meas_valid <= valid_d;
      vs_prev    <= vsync;
      de_prev    <= de;
    end
  end

  // A line ending on the vsync ce is folded into the counters before they are latched.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    lw_d    = lw_q;
    h_d     = h_active;
    v_d     = v_active;
    valid_d = meas_valid;
    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          pix_d   = '0;
          line_d  = '0;
          lw_d    = '0;
        end
      end
      ACTIVE: begin
        if (de) begin
          if (pix_q == CNT_MAX) state_d = WAIT_VS;
          else                  pix_d   = pix_q + MEAS_W'(1);
        end else if (de_fall) begin
          if (line_q == CNT_MAX) begin
            state_d = WAIT_VS;
          end else begin
            lw_d   = pix_q;
            pix_d  = '0;
            line_d = line_q + MEAS_W'(1);
          end
        end
        if (vs_rise) begin
          state_d = ACTIVE;
          h_d     = lw_d;
          v_d     = line_d;
          valid_d = 1'b1;
          pix_d   = '0;
          line_d  = '0;
          lw_d    = '0;
        end
      end
      WAIT_VS: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          h_d     = (pix_q == CNT_MAX) ? pix_q : lw_q;
          v_d     = line_q;
          valid_d = 1'b1;
          pix_d   = '0;
          line_d  = '0;
          lw_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/coco_video_out.sv
// CoCo video output stage: pixel clock-enable divider, colour expansion, blanking, aligned outputs.
// Define VIDEO_MEASURE_EN to build the active-area measurement unit (otherwise its outputs read 0).
module coco_video_out
  import coco_video_pkg::*;
#(
  parameter int unsigned IN_R_W = 5,
  parameter int unsigned IN_G_W = 6,
  parameter int unsigned IN_B_W = 5,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned CE_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_R_W-1:0] red,
  input  logic [IN_G_W-1:0] green,
  input  logic [IN_B_W-1:0] blue,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              hsync,
  input  logic              vsync,
  output logic              ce_pixel,
  output logic [OUT_W-1:0]  vga_r,
  output logic [OUT_W-1:0]  vga_g,
  output logic [OUT_W-1:0]  vga_b,
  output logic              vga_de,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic [MEAS_W-1:0] h_active,
  output logic [MEAS_W-1:0] v_active,
  output logic              meas_valid
);

  localparam int unsigned DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             de_c;

  assign de_c    = ~(hblank | vblank);
  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

  // ce_pixel is registered alongside div_cnt so it is high exactly while div_cnt is last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      ce_pixel <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      ce_pixel <= (div_nxt == DIV_LAST);
    end
  end

  // Every video signal passes through exactly one register stage, sampled on every clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_de <= 1'b0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
    end else begin
      vga_r  <= de_c ? OUT_W'(expand(32'(red),   IN_R_W, OUT_W)) : '0;
      vga_g  <= de_c ? OUT_W'(expand(32'(green), IN_G_W, OUT_W)) : '0;
      vga_b  <= de_c ? OUT_W'(expand(32'(blue),  IN_B_W, OUT_W)) : '0;
      vga_de <= de_c;
      vga_hs <= hsync;
      vga_vs <= vsync;
    end
  end

`ifdef VIDEO_MEASURE_EN
  coco_video_meas u_meas (
    .clk        (clk),
    .reset      (reset),
    .ce_pixel   (ce_pixel),
    .de         (de_c),
    .vsync      (vsync),
    .h_active   (h_active),
    .v_active   (v_active),
    .meas_valid (meas_valid)
  );
`else
  assign h_active   = '0;
  assign v_active   = '0;
  assign meas_valid = 1'b0;
`endif

endmodule
